// File: rtl/clk_mon_pkg.sv
// Shared definitions for the slow-clock edge monitor: FSM encoding and
// the width of the optional error counter.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int ERR_W = 16;

endpackage : clk_mon_pkg

// File: rtl/clk_edge_monitor_sync_edge_det.sv
// Synchroniser for an asynchronous slow clock, followed by a previous-sample
// register and registered one-cycle rise/fall pulses. A transition on sclk_i
// shows up on rise_o/fall_o SYNC_STAGES+1 clk_i edges later.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_out;
    logic                   edge_w;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_w   = sync_out ^ prev_q;

    // Shift the async input through the chain and register the edge pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sclk_i};
            prev_q <= sync_out;
            rise_q <= edge_w & sync_out;
            fall_q <= edge_w & ~sync_out;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule : sync_edge_det

// File: rtl/clk_edge_monitor.sv
// Receive-side monitor for a slow clock asynchronous to clk_i: edge pulses,
// half-period measurement and a lock FSM judged against exp_half_i.
// Optional feature macro: CLK_MON_ERRCNT_EN (counts bad edges and timeouts
// seen while LOCKED; otherwise err_cnt_o is tied to zero).
// Handshake note: there is no valid/ready pair here; rise_o/fall_o/lost_o are
// single-cycle strobes and half_per_o is valid from each edge pulse onwards.
import clk_mon_pkg::*;

module clk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_N      = 4,
    parameter int TOL         = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sclk_i,
    input  logic [CNT_W-1:0] exp_half_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] half_per_o,
    output logic             locked_o,
    output logic             lost_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output state_e           dbg_state_o
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             edge_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [GW-1:0]    good_q, good_d;
    state_e           state_q, state_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;
    logic [CNT_W:0]   meas;
    logic [CNT_W:0]   exp_ext;
    logic [CNT_W:0]   diff;
    logic             good_w;
    logic             timeout_w;
    logic             mon_on;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sclk_i (sclk_i),
        .rise_o (rise_o),
        .fall_o (fall_o)
    );

    assign edge_w    = rise_o | fall_o;
    assign meas      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign exp_ext   = {1'b0, exp_half_i};
    assign diff      = (meas >= exp_ext) ? (meas - exp_ext) : (exp_ext - meas);
    assign mon_on    = (exp_half_i != '0);
    assign good_w    = mon_on && (diff <= (CNT_W+1)'(TOL));
    assign timeout_w = (cnt_q == CNT_W'(TIMEOUT));

    // Half-period counter and measurement capture.
    always_comb begin
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        half_d = half_q;
        if (edge_w) begin
            cnt_d  = '0;
            half_d = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
        end
    end

    // Lock FSM next state; an edge takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        lost_d  = 1'b0;
        if (!mon_on) begin
            state_d = ST_IDLE;
            good_d  = '0;
            lost_d  = (state_q == ST_LOCKED);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    good_d = '0;
                    if (edge_w) state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (edge_w) begin
                        if (good_w) begin
                            if (good_q + GW'(1) == GW'(LOCK_N)) begin
                                state_d = ST_LOCKED;
                                good_d  = '0;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end else begin
                            good_d = '0;
                        end
                    end else if (timeout_w) begin
                        state_d = ST_IDLE;
                        good_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (edge_w) begin
                        if (!good_w) begin
                            state_d = ST_ACQ;
                            good_d  = '0;
                            lost_d  = 1'b1;
                        end
                    end else if (timeout_w) begin
                        state_d = ST_IDLE;
                        good_d  = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            half_q   <= '0;
            good_q   <= '0;
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            good_q   <= good_d;
            state_q  <= state_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

`ifdef CLK_MON_ERRCNT_EN
    logic [ERR_W-1:0] err_q;
    logic             err_inc;

    assign err_inc = (state_q == ST_LOCKED) && mon_on &&
                     ((edge_w && !good_w) || (!edge_w && timeout_w));

    // Saturating count of unlock events caused by bad edges or timeouts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = '0;
`endif

    assign half_per_o  = half_q;
    assign locked_o    = locked_q;
    assign lost_o      = lost_q;
    assign dbg_state_o = state_q;

endmodule : clk_edge_monitor

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor: a clk_gen-like slow clock generator,
// pulse/lost counting monitor, and one task per scenario.
import clk_mon_pkg::*;

module tb_clk_edge_monitor;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic [7:0]  exp_half;
    logic        rise, fall, locked, lost;
    logic [7:0]  half_per;
    logic [15:0] err_cnt;
    state_e      dbg_state;

    int errors = 0;
    int checks = 0;

    // generator controls
    logic gen_run  = 1'b0;
    logic sclk_man = 1'b0;
    int   gen_half_a = 4;
    int   gen_half_b = 4;

    // monitor counters
    int   edge_cnt = 0;
    int   lost_cnt = 0;
    logic err_seen = 1'b0;

    clk_edge_monitor dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sclk_i      (sclk),
        .exp_half_i  (exp_half),
        .rise_o      (rise),
        .fall_o      (fall),
        .half_per_o  (half_per),
        .locked_o    (locked),
        .lost_o      (lost),
        .err_cnt_o   (err_cnt),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // slow clock generator: toggles after gen_half_a / gen_half_b cycles alternately
    initial begin
        int  ctr;
        logic use_a;
        ctr   = 0;
        use_a = 1'b1;
        sclk  = 1'b0;
        forever begin
            @(negedge clk);
            if (!gen_run) begin
                sclk  = sclk_man;
                ctr   = 0;
                use_a = 1'b1;
            end else begin
                ctr++;
                if (ctr >= (use_a ? gen_half_a : gen_half_b)) begin
                    sclk  = ~sclk;
                    ctr   = 0;
                    use_a = ~use_a;
                end
            end
        end
    end

    // monitor: counts edge and lost pulses
    initial begin
        forever begin
            @(negedge clk);
            if (rise || fall) edge_cnt++;
            if (lost) lost_cnt++;
            if (err_cnt != 16'h0) err_seen = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic stop_gen();
        sclk_man = sclk;
        gen_run  = 1'b0;
        step();
    endtask

    task automatic restart_gen(input int a, input int b);
        gen_half_a = a;
        gen_half_b = b;
        gen_run    = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_lock(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_lost(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (lost) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // stop, reset, run with given half-periods at exp 4 and wait for lock
    task automatic relock(input int a, input int b, input string tag);
        logic ok;
        stop_gen();
        exp_half = 8'd4;
        pulse_reset();
        restart_gen(a, b);
        wait_lock(200, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s_relock: locked=%0b required 1 within 200 cycles", tag, locked);
        end
    endtask

    task automatic test_reset();
        gen_run  = 1'b0;
        sclk_man = 1'b0;
        exp_half = 8'd4;
        rst      = 1'b1;
        repeat (3) step();
        checks++;
        if ({rise, fall, locked, lost} !== 4'b0000 || half_per !== 8'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: rise=%0b fall=%0b locked=%0b lost=%0b half=%0d err=%0d required all 0",
                     rise, fall, locked, lost, half_per, err_cnt);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({rise, fall, locked, lost} !== 4'b0000 || half_per !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: rise=%0b fall=%0b locked=%0b lost=%0b half=%0d required all 0",
                     rise, fall, locked, lost, half_per);
        end
    endtask

    task automatic test_latency();
        int n;
        // rising transition
        sclk_man = 1'b1;
        step();
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (rise) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL rise_latency: cycles=%0d required 3", n);
        end
        repeat (4) step();
        // falling transition
        sclk_man = 1'b0;
        step();
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (fall) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL fall_latency: cycles=%0d required 3", n);
        end
        checks++;
        if (rise !== 1'b0) begin
            errors++;
            $display("FAIL fall_no_rise: rise=%0b required 0", rise);
        end
    endtask

    task automatic test_lock();
        logic ok;
        int   e0, l0, n;
        stop_gen();
        sclk_man = 1'b0;
        step();
        step();
        exp_half = 8'd4;
        pulse_reset();
        e0 = edge_cnt;
        l0 = lost_cnt;
        restart_gen(4, 4);
        wait_lock(200, ok);
        checks++;
        if (ok !== 1'b1 || (edge_cnt - e0) !== 5) begin
            errors++;
            $display("FAIL lock_edges: locked=%0b edges=%0d required locked at edge 5", ok, edge_cnt - e0);
        end
        checks++;
        if (half_per !== 8'd4) begin
            errors++;
            $display("FAIL lock_half_per: half_per=%0d required 4", half_per);
        end
        // rise to fall spacing
        for (int i = 0; i < 20; i++) begin
            step();
            if (rise) break;
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (fall) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rise_fall_spacing: cycles=%0d required 4", n);
        end
        checks++;
        if (lost_cnt !== l0 || locked !== 1'b1 || dbg_state !== ST_LOCKED) begin
            errors++;
            $display("FAIL lock_stable: lost_pulses=%0d locked=%0b state=%0d required 0/1/%0d",
                     lost_cnt - l0, locked, dbg_state, ST_LOCKED);
        end
    endtask

    task automatic test_freq_change();
        logic ok;
        int   l0;
        l0 = lost_cnt;
        gen_half_a = 6;
        gen_half_b = 6;
        wait_lost(50, ok);
        checks++;
        if (ok !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL freq_lost: lost_seen=%0b locked=%0b required 1/0", ok, locked);
        end
        repeat (40) step();
        checks++;
        if (half_per !== 8'd6 || dbg_state !== ST_ACQ) begin
            errors++;
            $display("FAIL freq_acq: half_per=%0d state=%0d required 6/%0d", half_per, dbg_state, ST_ACQ);
        end
        checks++;
        if ((lost_cnt - l0) !== 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL freq_single_lost: lost_pulses=%0d locked=%0b required 1/0", lost_cnt - l0, locked);
        end
    endtask

    task automatic test_timeout();
        logic ok;
        int   n, e0;
        relock(4, 4, "timeout");
        for (int i = 0; i < 20; i++) begin
            step();
            if (rise || fall) break;
        end
        gen_run  = 1'b0;
        sclk_man = sclk;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            step();
            if (lost) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 257) begin
            errors++;
            $display("FAIL timeout_delay: cycles_after_pulse=%0d required 257", n);
        end
        checks++;
        if (dbg_state !== ST_IDLE || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: state=%0d locked=%0b required %0d/0", dbg_state, locked, ST_IDLE);
        end
        e0 = edge_cnt;
        restart_gen(4, 4);
        wait_lock(200, ok);
        checks++;
        if (ok !== 1'b1 || (edge_cnt - e0) !== 5) begin
            errors++;
            $display("FAIL timeout_relock: locked=%0b edges=%0d required locked at edge 5", ok, edge_cnt - e0);
        end
    endtask

    task automatic test_tolerance();
        logic any_locked;
        relock(3, 5, "tol_in");
        checks++;
        if (dbg_state !== ST_LOCKED) begin
            errors++;
            $display("FAIL tol_in_state: state=%0d required %0d", dbg_state, ST_LOCKED);
        end
        stop_gen();
        pulse_reset();
        restart_gen(2, 6);
        any_locked = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (locked) any_locked = 1'b1;
        end
        checks++;
        if (any_locked !== 1'b0 || dbg_state !== ST_ACQ) begin
            errors++;
            $display("FAIL tol_out: locked_seen=%0b state=%0d required 0/%0d", any_locked, dbg_state, ST_ACQ);
        end
    endtask

    task automatic test_monitor_off();
        int l0;
        relock(4, 4, "off");
        l0 = lost_cnt;
        exp_half = 8'd0;
        step();
        step();
        checks++;
        if ((lost_cnt - l0) !== 1 || locked !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL off_force_idle: lost_pulses=%0d locked=%0b state=%0d required 1/0/%0d",
                     lost_cnt - l0, locked, dbg_state, ST_IDLE);
        end
        repeat (20) step();
        checks++;
        if (half_per !== 8'd4 || dbg_state !== ST_IDLE || (lost_cnt - l0) !== 1) begin
            errors++;
            $display("FAIL off_measure: half_per=%0d state=%0d lost_pulses=%0d required 4/%0d/1",
                     half_per, dbg_state, lost_cnt - l0, ST_IDLE);
        end
        exp_half = 8'd4;
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   l0;
        relock(4, 4, "rstmid");
        l0 = lost_cnt;
        rst = 1'b1;
        step();
        checks++;
        if ({rise, fall, locked, lost} !== 4'b0000 || half_per !== 8'd0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmid_outputs: rise=%0b fall=%0b locked=%0b lost=%0b half=%0d state=%0d required all 0",
                     rise, fall, locked, lost, half_per, dbg_state);
        end
        rst = 1'b0;
        wait_lock(200, ok);
        checks++;
        if (ok !== 1'b1 || lost_cnt !== l0) begin
            errors++;
            $display("FAIL rstmid_reacquire: locked=%0b lost_pulses=%0d required 1/0", ok, lost_cnt - l0);
        end
    endtask

    task automatic test_err_cnt();
        logic ok;
        relock(4, 4, "err");
        for (int k = 0; k < 3; k++) begin
            gen_half_a = 6;
            gen_half_b = 6;
            wait_lost(50, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL err_unlock_%0d: lost_seen=%0b required 1", k, ok);
            end
            gen_half_a = 4;
            gen_half_b = 4;
            wait_lock(200, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL err_relock_%0d: locked=%0b required 1", k, ok);
            end
        end
`ifdef CLK_MON_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL err_count: err_cnt=%0d required 3", err_cnt);
        end
`else
        checks++;
        if (err_cnt !== 16'd0 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL err_tied_zero: err_cnt=%0d nonzero_seen=%0b required 0/0", err_cnt, err_seen);
        end
`endif
    endtask

    initial begin
        rst      = 1'b1;
        exp_half = 8'd4;
        test_reset();
        test_latency();
        test_lock();
        test_freq_change();
        test_timeout();
        test_tolerance();
        test_monitor_off();
        test_reset_mid();
        test_err_cnt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_clk_edge_monitor
